// File: rtl/timer_pkg.sv
// Shared types and helpers for the interval timer arbiter.
// State encoding is fixed: IDLE=0, COUNT=1, DONE=2.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // (base + off) mod m, valid for base < m and off < m
    function automatic int unsigned wrap_inc(int unsigned base, int unsigned off,
                                             int unsigned m);
        int unsigned s;
        s = base + off;
        return (s >= m) ? s - m : s;
    endfunction

endpackage

// File: rtl/interval_counter.sv
// Loadable down-counter; saturates at zero and flags the last count.
module interval_counter #(
    parameter int unsigned N = 8
) (
    input  logic         clock,
    input  logic         clear_n,
    input  logic         load,
    input  logic [N-1:0] load_val,
    input  logic         dec,
    output logic [N-1:0] q,
    output logic         is_one
);

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (dec && (q != '0)) begin
            q <= q - 1'b1;
        end
    end

    assign is_one = (q == N'(1));

endmodule

// File: rtl/interval_timer_arbiter.sv
// Round-robin arbiter granting a shared interval down-counter to one of NREQ requesters.
// grant/done/busy are decoded from registered state only.
module interval_timer_arbiter
    import timer_pkg::*;
#(
    parameter int unsigned N    = 8,
    parameter int unsigned NREQ = 4
) (
    input  logic              clock,
    input  logic              clear_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*N-1:0] len,
    output logic [NREQ-1:0]   grant,
    output logic [NREQ-1:0]   done,
    output logic              busy,
    output logic [N-1:0]      q
);

    localparam int unsigned IW = $clog2(NREQ);

    state_t          state_q, state_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   winner;
    logic [IW-1:0]   owner_next;
    logic [NREQ-1:0] rot;
    logic            found;
    logic [N-1:0]    len_win;
    logic            load;
    logic [N-1:0]    load_val;
    logic            dec;
    logic            is_one;

    // rot[i] is the request of requester (ptr + i) mod NREQ
    always_comb begin
        rot = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            rot[i] = req[IW'(wrap_inc(32'(ptr_q), i, NREQ))];
        end
    end

    always_comb begin
        winner = ptr_q;
        found  = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (rot[i] && !found) begin
                winner = IW'(wrap_inc(32'(ptr_q), i, NREQ));
                found  = 1'b1;
            end
        end
    end

    assign len_win    = len[32'(winner)*N +: N];
    assign owner_next = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        ptr_d    = ptr_q;
        load     = 1'b0;
        load_val = '0;
        dec      = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    owner_d  = winner;
                    load     = 1'b1;
                    load_val = len_win;
                    state_d  = (len_win != '0) ? COUNT : DONE;
                end
            end
            COUNT: begin
                if (!req[owner_q]) begin
                    // owner gave up: clear the counter, no done pulse
                    load    = 1'b1;
                    state_d = IDLE;
                    ptr_d   = owner_next;
                end else begin
                    dec = 1'b1;
                    if (is_one) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                ptr_d   = owner_next;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end

    interval_counter #(
        .N(N)
    ) u_counter (
        .clock   (clock),
        .clear_n (clear_n),
        .load    (load),
        .load_val(load_val),
        .dec     (dec),
        .q       (q),
        .is_one  (is_one)
    );

    always_comb begin
        grant = '0;
        done  = '0;
        if (state_q != IDLE) begin
            grant[owner_q] = 1'b1;
        end
        if (state_q == DONE) begin
            done[owner_q] = 1'b1;
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_interval_timer_arbiter.sv
// Scoreboard bench: the driver pushes expected grant episodes from a round-robin model,
// the monitor pops one per observed grant and checks owner, q, done, busy and length.
module tb_interval_timer_arbiter;

    localparam int N    = 8;
    localparam int NREQ = 4;

    logic              clock;
    logic              clear_n;
    logic [NREQ-1:0]   req;
    logic [NREQ*N-1:0] len;
    logic [NREQ-1:0]   grant;
    logic [NREQ-1:0]   done;
    logic              busy;
    logic [N-1:0]      q;

    interval_timer_arbiter #(
        .N   (N),
        .NREQ(NREQ)
    ) dut (
        .clock  (clock),
        .clear_n(clear_n),
        .req    (req),
        .len    (len),
        .grant  (grant),
        .done   (done),
        .busy   (busy),
        .q      (q)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int owner;
        int len;
        int ncyc;      // negedge samples with grant high
        int done_idx;  // sample index carrying done, -1 for none
        int gap;       // idle samples before this grant, -1 for don't care
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   mptr   = 0;
    bit   in_ep  = 0;

    task automatic chk(input string name, input int act, input int req_v);
        checks++;
        if (act != req_v) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req_v, $time);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    // Every requester in r holds until its own done, then drops.
    task automatic push_set(input logic [NREQ-1:0] r, input logic [NREQ*N-1:0] l);
        logic [NREQ-1:0] rem;
        bit first;
        rem   = r;
        first = 1'b1;
        while (rem != '0) begin
            int   w;
            exp_t e;
            w          = pick(rem, mptr);
            e.owner    = w;
            e.len      = int'(l[w*N +: N]);
            e.ncyc     = e.len + 1;
            e.done_idx = e.len;
            e.gap      = first ? -1 : 1;
            exp_q.push_back(e);
            rem[w] = 1'b0;
            mptr   = (w + 1) % NREQ;
            first  = 1'b0;
        end
    endtask

    task automatic wait_dones(input int n, input bit drop_each, input int budget);
        int cnt;
        int cyc;
        cnt = 0;
        cyc = 0;
        while (cnt < n && cyc < budget) begin
            @(negedge clock);
            cyc++;
            if (done != '0) begin
                cnt++;
                if (drop_each) req = req & ~done;
                else if (cnt == n) req = '0;
            end
        end
        if (cnt < n) chk("wait_done_timeout", cnt, n);
    endtask

    // Monitor
    initial begin
        exp_t cur;
        int   k;
        int   idle_cnt;
        k        = 0;
        idle_cnt = 0;
        forever begin
            @(negedge clock or negedge clear_n);
            if (!clear_n) begin
                in_ep    = 1'b0;
                idle_cnt = 0;
            end else if (!in_ep && grant == '0) begin
                idle_cnt++;
                chk("idle_busy", int'(busy), 0);
                chk("idle_done", int'(done), 0);
                chk("idle_q", int'(q), 0);
            end else if (in_ep && grant == '0) begin
                chk("grant_cycles", k, cur.ncyc);
                chk("end_q", int'(q), 0);
                chk("end_done", int'(done), 0);
                in_ep    = 1'b0;
                idle_cnt = 1;
            end else begin
                if (!in_ep) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_grant", int'(grant), 0);
                        continue;
                    end
                    cur   = exp_q.pop_front();
                    in_ep = 1'b1;
                    k     = 0;
                    if (cur.gap >= 0) chk("idle_gap", idle_cnt, cur.gap);
                end
                chk("grant", int'(grant), 1 << cur.owner);
                chk("q", int'(q), (k < cur.len) ? cur.len - k : 0);
                chk("done", int'(done), (k == cur.done_idx) ? (1 << cur.owner) : 0);
                chk("busy", int'(busy), 1);
                k++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    // Driver
    initial begin
        exp_t e;
        int   cyc;
        logic [NREQ-1:0] r;
        clear_n = 1'b0;
        req     = '0;
        len     = '0;
        repeat (3) @(negedge clock);
        chk("rst_grant", int'(grant), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_q", int'(q), 0);
        clear_n = 1'b1;
        mptr    = 0;
        repeat (2) @(negedge clock);

        // Round robin with all four held: 0,1,2,3,0
        len = {8'd2, 8'd2, 8'd2, 8'd2};
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            int w;
            w          = pick(4'b1111, mptr);
            e.owner    = w;
            e.len      = 2;
            e.ncyc     = 3;
            e.done_idx = 2;
            e.gap      = (i == 0) ? -1 : 1;
            exp_q.push_back(e);
            mptr = (w + 1) % NREQ;
        end
        wait_dones(5, 1'b0, 200);
        repeat (3) @(negedge clock);

        // Single request, len changed after selection must not matter
        len       = '0;
        len[7:0]  = 8'd5;
        req       = 4'b0001;
        push_set(req, len);
        @(posedge clock);
        #1 len[7:0] = 8'd77;
        wait_dones(1, 1'b1, 100);
        repeat (2) @(negedge clock);

        // Abandon after three COUNT cycles
        len        = '0;
        len[15:8]  = 8'd10;
        req        = 4'b0010;
        exp_q.push_back('{owner: 1, len: 10, ncyc: 4, done_idx: -1, gap: -1});
        mptr = 2;
        @(posedge clock);
        repeat (3) @(posedge clock);
        #1 req = 4'b0000;
        repeat (3) @(negedge clock);
        len = {8'd1, 8'd1, 8'd1, 8'd1};
        req = 4'b0111;
        push_set(req, len);
        wait_dones(3, 1'b1, 100);
        repeat (2) @(negedge clock);

        // Zero length
        len         = '0;
        req         = 4'b0100;
        push_set(req, len);
        wait_dones(1, 1'b1, 50);
        repeat (2) @(negedge clock);

        // Full-width interval
        len       = '0;
        len[7:0]  = 8'd255;
        req       = 4'b0001;
        push_set(req, len);
        wait_dones(1, 1'b1, 400);
        repeat (2) @(negedge clock);

        // Reset in the middle of a long interval
        len       = '0;
        len[7:0]  = 8'd200;
        req       = 4'b0001;
        push_set(req, len);
        repeat (20) @(negedge clock);
        #2 clear_n = 1'b0;
        #1;
        chk("midrst_grant", int'(grant), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_q", int'(q), 0);
        len       = '0;
        len[7:0]  = 8'd3;
        len[31:24] = 8'd4;
        req       = 4'b1001;
        mptr      = 0;
        push_set(req, len);
        #6 clear_n = 1'b1;
        wait_dones(2, 1'b1, 100);
        repeat (2) @(negedge clock);

        // Randomized request sets
        for (int it = 0; it < 25; it++) begin
            r = 4'($urandom_range(1, 15));
            for (int i = 0; i < NREQ; i++) len[i*N +: N] = 8'($urandom_range(0, 9));
            req = r;
            push_set(r, len);
            wait_dones($countones(r), 1'b1, 500);
            repeat ($urandom_range(0, 3)) @(negedge clock);
        end

        cyc = 0;
        while ((exp_q.size() != 0 || in_ep) && cyc < 100) begin
            @(negedge clock);
            cyc++;
        end
        repeat (2) @(negedge clock);
        chk("episodes_left", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/interval_timer_arbiter.md
INTERVAL_TIMER_ARBITER -- requirements
Module: interval_timer_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 8, giving the counter and interval-length width in bits.
REQ-002 The block SHALL have parameter NREQ, default 4, giving the number of requesters (2..8).
REQ-003 The block SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port clear_n, input, 1, reset, asynchronous and active-low.
REQ-005 The block SHALL have port req, input, NREQ, a per-requester interval request, level, held until done or abandon.
REQ-006 The block SHALL have port len, input, NREQ*N, packed interval lengths; slice i is len[i*N +: N].
REQ-007 The block SHALL have port grant, output, NREQ, one-hot owner of the counter; all zero when idle.
REQ-008 The block SHALL have port done, output, NREQ, a one-cycle pulse to the owner at interval expiry.
REQ-009 The block SHALL have port busy, output, 1, high while any state other than IDLE is active.
REQ-010 The block SHALL have port q, output, N, the current counter value.

Function
REQ-011 The FSM SHALL have exactly three states, IDLE, COUNT and DONE, with a registered state.
REQ-012 In IDLE with req nonzero, the block SHALL select a winner round-robin, searching upward from pointer ptr with wrap at NREQ-1 to 0.
REQ-013 On the selecting edge, the block SHALL latch the winner index and load q with len of the winner.
REQ-014 If the loaded len is nonzero, the next state SHALL be COUNT; if it is zero, the next state SHALL be DONE.
REQ-015 In COUNT, q SHALL decrement by 1 per cycle; on the edge where q equals 1, q SHALL become 0 and the state SHALL go to DONE.
REQ-016 For a request sampled at edge t with length L of 1 or more, grant SHALL be high from t through t+L+1 and done SHALL be high only in the cycle between t+L and t+L+1.
REQ-017 In DONE, done[owner] SHALL be 1 for exactly one cycle, ptr SHALL become (owner+1) mod NREQ, and the state SHALL return to IDLE.
REQ-018 grant[owner] SHALL be high in COUNT and DONE and SHALL be all zero in IDLE.
REQ-019 If req[owner] drops during COUNT, the block SHALL abandon the interval: go to IDLE next edge, assert no done, clear q to 0, and set ptr to owner+1.
REQ-020 Requests from non-owners during COUNT or DONE SHALL be ignored until IDLE; no pre-emption.
REQ-021 A requester holding req through DONE SHALL be re-eligible in the following IDLE cycle, behind the others in round-robin order.
REQ-022 len SHALL be sampled only on the selecting edge; later changes SHALL NOT affect the running interval.
REQ-023 The minimum turnaround SHALL be one IDLE cycle between a DONE and the next grant.
REQ-024 All outputs SHALL be registered or decoded only from registered state; there SHALL be no combinational path from req to grant.

Reset
REQ-025 While clear_n is 0, the block SHALL immediately force state to IDLE, q to 0, ptr to 0, grant to 0, done to 0 and busy to 0.
REQ-026 Reset asserted mid-COUNT SHALL drop the interval with no done pulse; operation SHALL resume on the first edge after clear_n is 1.

Structure
REQ-027 State encodings (IDLE=0, COUNT=1, DONE=2) and the state typedef SHALL live in the shared package timer_pkg.
REQ-028 The loadable down-counter SHALL be one sub-module, interval_counter, with parameter N and ports clock, clear_n, load, load_val, dec, q and is_one.
REQ-029 The round-robin selection SHALL stay in the top module as a priority search over rotated req.

Verification
REQ-030 The bench SHALL cover single request: req=0001, len0=5 at edge t -> grant=0001 over t..t+6, done[0] pulse between t+5 and t+6, q sequence 5,4,3,2,1,0.
REQ-031 The bench SHALL cover round-robin: req=1111 held, all len=2 -> grants in order 0001,0010,0100,1000,0001, each done one cycle, one IDLE cycle between.
REQ-032 The bench SHALL cover zero length: req=0100, len2=0 -> grant=0100 for 1 cycle in DONE, done[2] pulse the next cycle after selection, q=0.
REQ-033 The bench SHALL cover abandon: req=0010, len1=10, req drops after 3 COUNT cycles -> IDLE next edge, no done, q=0, next grant goes to requester 2 or above.
REQ-034 The bench SHALL cover mid-count reset: len0=200 running, clear_n=0 for 7 ns asynchronously -> all outputs 0 immediately, no done pulse, fresh arbitration from ptr=0.
REQ-035 The bench SHALL cover wrap at width: N=8, len=255 -> exactly 255 COUNT cycles, done once, no underflow past 0.
